// File: rtl/div_signed_seq_pkg.sv
// Shared arithmetic definitions for the sequential signed divider and its
// companion multiplier benches.
package div_signed_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(8);

  // Callers truncate the result to their own width. The low bits of a
  // two's-complement negate do not depend on how far the operand was extended.
  function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_signed_seq_if.sv
// Operand and result handshakes of the sequential signed divider.
interface div_signed_seq_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic                    div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_restoring_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next,
  output logic             trial_neg
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // The working remainder stays below the divisor, so one spare bit above it
  // is enough to carry the borrow of the trial subtraction.
  assign shifted   = {rem, quo[WIDTH-1]};
  assign trial     = shifted - {2'b00, dsr};
  assign trial_neg = trial[WIDTH+1];
  assign rem_next  = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
  assign quo_next  = {quo[WIDTH-2:0], ~trial_neg};
endmodule

// File: rtl/div_signed_seq.sv
// Sequential signed divider: one restoring step per clock on the operand
// magnitudes, then a sign fix. The quotient truncates toward zero.
module div_signed_seq
  import div_signed_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  div_signed_seq_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  div_state_e state, state_next;

  logic [CW-1:0]           cnt;
  logic [WIDTH:0]          rem_r;
  logic [WIDTH:0]          rem_nx;
  logic [WIDTH-1:0]        quo_r;
  logic [WIDTH-1:0]        quo_nx;
  logic [WIDTH-1:0]        dsr_r;
  logic signed [WIDTH-1:0] quotient_r;
  logic signed [WIDTH-1:0] remainder_r;
  logic                    sign_q;
  logic                    sign_r;
  logic                    dbz_r;
  logic                    trial_neg_unused;
  logic [WIDTH-1:0]        dividend_mag;
  logic [WIDTH-1:0]        divisor_mag;
  logic                    divisor_zero;
  logic                    div_last;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) exactly.
  assign dividend_mag = WIDTH'(cond_neg(64'(bus.dividend), bus.dividend[WIDTH-1]));
  assign divisor_mag  = WIDTH'(cond_neg(64'(bus.divisor), bus.divisor[WIDTH-1]));
  assign divisor_zero = (bus.divisor == '0);
  assign div_last     = (cnt == CW'(WIDTH - 1));

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem_r),
    .quo       (quo_r),
    .dsr       (dsr_r),
    .rem_next  (rem_nx),
    .quo_next  (quo_nx),
    .trial_neg (trial_neg_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = divisor_zero ? DONE : DIV;
      DIV:     if (div_last) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dsr_r       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r <= bus.dividend[WIDTH-1];
            rem_r  <= '0;
            quo_r  <= dividend_mag;
            dsr_r  <= divisor_mag;
            cnt    <= '0;
            if (divisor_zero) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end
          end
        end
        DIV: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          // The remainder is below |divisor| <= 2^(WIDTH-1), so its low WIDTH bits hold it.
          quotient_r  <= WIDTH'(cond_neg(64'(quo_r), sign_q));
          remainder_r <= WIDTH'(cond_neg(64'(rem_r[WIDTH-1:0]), sign_r));
          dbz_r       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule
